lector_sensor_temp: RTL and testbench
=====================================

# lector_sensor_temp

- Serial front-end that reads a 16-bit frame from a thermocouple/ADC temperature sensor over a 3-wire SPI-style link: `cs_n`, `sclk`, `miso`.
- Converts the 12-bit reading (0.25 °C/LSB) to tenths of °C and presents it as `temp_entrada` with a one-cycle valid strobe.
- Sits upstream of `monitoreo_top`: it is the producer side of the temperature-sample interface the monitor consumes.
- In production it replaces the bench driver that pushes temperatures into the monitor.

## Interface

Parameters
- `DIV_SCLK`, default 4: clk cycles per `sclk` half-period; legal values ≥ 3.
- `PAUSA_CICLOS`, default 1000: idle cycles between frames in automatic mode; legal values ≥ 1.
- `ANCHO_TEMP`, default 10: width of `temp_entrada` in tenths of °C.

Ports
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `inicio` in 1: request one conversion; sampled only in IDLE.
- `auto_en` in 1: continuous conversion mode.
- `miso` in 1: sensor serial data, asynchronous to `clk`.
- `cs_n` out 1: sensor chip select, active low.
- `sclk` out 1: serial clock; idles low.
- `temp_entrada` out `ANCHO_TEMP`: last good temperature in tenths of °C, saturated.
- `dato_valido` out 1: one-cycle pulse when a frame completes.
- `falla` out 1: open-input flag from the last frame.
- `ocupado` out 1: high in every state except IDLE.

## Operation

- **Input synchronisation:** `miso` passes through a 2-flop synchronizer; only the synchronized value is used.
- **FSM states:** IDLE, SETUP, BAJO, ALTO, FIN, PAUSA.
- **IDLE:** `cs_n`=1, `sclk`=0. Moves to SETUP when `inicio`=1 or `auto_en`=1.
- **SETUP:** `cs_n`=0 for DIV_SCLK cycles, then BAJO.
- **BAJO:** `sclk`=0 for DIV_SCLK cycles, then ALTO.
- **ALTO:** `sclk`=1 for DIV_SCLK cycles.
  - On the last ALTO cycle, shift the synchronized `miso` into a 16-bit register, MSB first.
  - Increment the bit counter (0..15).
  - After bit 15, go to FIN; otherwise go to BAJO.
- **FIN:** `cs_n`=1, `sclk`=0 for one cycle; decode the frame.
  - Next state is PAUSA if `auto_en`=1, else IDLE.
- **PAUSA:** counts PAUSA_CICLOS cycles, then SETUP.
  - If `auto_en` drops during PAUSA, go to IDLE on the next cycle.
- **Frame layout:**
  - bit 15: dummy, ignored.
  - bits 14:3: `raw`, unsigned, 0.25 °C/LSB.
  - bit 2: open input.
  - bits 1:0: ignored.
- **Conversion:** tenths = (raw × 5) >> 1, truncating.
  - Intermediate width 14 bits; maximum value 10237.
  - If the result exceeds 2^ANCHO_TEMP − 1, saturate to 2^ANCHO_TEMP − 1.
- **Output update:**
  - `dato_valido` pulses one cycle after FIN.
  - `falla` takes bit 2 of the frame.
  - `temp_entrada` is updated only when bit 2 = 0; on a fault frame it holds its previous value.
- **`inicio` handling:** ignored while `ocupado`=1; it is not queued.
- **`auto_en` during a frame:** changes affect only the FIN/PAUSA decision; the current frame always completes.

## Timing

- **Reset values:**
  - `cs_n`=1, `sclk`=0, `temp_entrada`=0, `dato_valido`=0, `falla`=0, `ocupado`=0.
  - FSM in IDLE, synchronizer and shift register cleared.
- **Cycle numbering:** `inicio` is seen in IDLE at cycle 0.
- **Chip select:** `cs_n` falls at cycle 1 and stays low for 33×DIV_SCLK cycles; it rises at cycle 1+33×DIV_SCLK (133 at default).
- **Valid strobe:** `dato_valido` is high at cycle 2+33×DIV_SCLK (134 at default). `temp_entrada` and `falla` change in that same cycle.
- **First clock edge:** the first `sclk` rising edge is at cycle 1+2×DIV_SCLK.
- **Sampling margin:** the sample point is the last cycle of each ALTO phase. The sensor changes data on `sclk` falling edges, so the 2-flop synchronizer latency fits within the high phase when DIV_SCLK ≥ 3.
- **Auto-mode frame period:** 33×DIV_SCLK + 2 + PAUSA_CICLOS cycles from one `cs_n` fall to the next.
- **`ocupado`:** high from cycle 1 until the cycle `dato_valido` pulses, inclusive.
- **Reset mid-frame:** on the next edge `cs_n`=1, `sclk`=0, FSM returns to IDLE, all outputs take reset values, and the partial frame is discarded with no `dato_valido`.
- **Simultaneous `inicio` and `auto_en` in IDLE:** only one frame starts; the FIN decision follows `auto_en`.

## Test plan

- **Normal reading:** reset, then `inicio` with sensor model returning 0x0500 (raw 160).
  - Required: `temp_entrada`=400, `falla`=0, `dato_valido` exactly at cycle 134.
  - `cs_n` low for 132 cycles, exactly 16 `sclk` rising edges.
- **Truncation:** frame 0x0248 (raw 73).
  - Required: `temp_entrada`=182.
- **Saturation:** frame 0x7FF8 (raw 4095).
  - Required: `temp_entrada`=1023 with ANCHO_TEMP=10.
- **Open input:** frame 0x0500 first, then 0x0504.
  - Required: second `dato_valido` has `falla`=1 and `temp_entrada` still 400.
  - A following frame 0x0500 clears `falla`.
- **Automatic mode:** `auto_en`=1 with PAUSA_CICLOS=10.
  - Required: consecutive `cs_n` falls exactly 144 cycles apart.
  - Dropping `auto_en` during PAUSA gives IDLE on the next cycle.
  - `inicio` pulses during a frame start no extra frames.
- **Reset mid-frame:** assert `rst` after bit 7.
  - Required: next cycle `cs_n`=1, `sclk`=0, `temp_entrada`=0, `ocupado`=0, and no `dato_valido` pulse.

Source files
------------

// File: rtl/lector_sensor_temp.sv
// Serial front-end for a 16-bit SPI temperature sensor: clocks out one frame,
// converts the 12-bit 0.25 degC reading to saturated tenths of degC.
module lector_sensor_temp #(
    parameter int DIV_SCLK     = 4,
    parameter int PAUSA_CICLOS = 1000,
    parameter int ANCHO_TEMP   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic                  auto_en,
    input  logic                  miso,
    output logic                  cs_n,
    output logic                  sclk,
    output logic [ANCHO_TEMP-1:0] temp_entrada,
    output logic                  dato_valido,
    output logic                  falla,
    output logic                  ocupado
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BAJO,
        ALTO,
        FIN,
        PAUSA
    } estado_t;

    // PAUSA spends PAUSA_CICLOS+1 cycles so the frame period is 33*DIV+2+PAUSA.
    localparam int CNT_MAX  = (DIV_SCLK > PAUSA_CICLOS + 1) ? DIV_SCLK : PAUSA_CICLOS + 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int TEMP_MAX = (1 << ANCHO_TEMP) - 1;

    localparam logic [CNT_W-1:0] FIN_DIV   = CNT_W'(DIV_SCLK - 1);
    localparam logic [CNT_W-1:0] FIN_PAUSA = CNT_W'(PAUSA_CICLOS);

    estado_t                 estado, estado_sig;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              n_bit;
    logic [15:0]             trama;
    logic                    miso_s1, miso_s2;
    logic                    fin_fase;

    logic [11:0]             raw;
    logic [14:0]             producto;
    logic [13:0]             decimas;
    logic [ANCHO_TEMP-1:0]   temp_sat;
    logic                    trama_unused;

    assign fin_fase = (cnt == FIN_DIV);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if ((inicio || auto_en) && !ocupado) estado_sig = SETUP;
            SETUP:   if (fin_fase) estado_sig = BAJO;
            BAJO:    if (fin_fase) estado_sig = ALTO;
            ALTO:    if (fin_fase) estado_sig = (n_bit == 4'd15) ? FIN : BAJO;
            FIN:     estado_sig = auto_en ? PAUSA : IDLE;
            PAUSA: begin
                if (!auto_en)              estado_sig = IDLE;
                else if (cnt == FIN_PAUSA) estado_sig = SETUP;
            end
            default: estado_sig = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            cnt     <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            estado  <= estado_sig;
            cnt     <= (estado_sig != estado) ? '0 : cnt + 1'b1;
            cs_n    <= !(estado_sig inside {SETUP, BAJO, ALTO});
            sclk    <= (estado_sig == ALTO);
            // Stays high through the strobe cycle so a late inicio cannot restart.
            ocupado <= (estado_sig != IDLE) || (estado == FIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
            n_bit   <= '0;
            trama   <= '0;
        end else begin
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
            if (estado == SETUP) begin
                n_bit <= '0;
            end else if (estado == ALTO && fin_fase) begin
                trama <= {trama[14:0], miso_s2};
                n_bit <= n_bit + 1'b1;
            end
        end
    end

    // tenths = raw * 2.5, truncated; raw*5 needs 15 bits before the halving.
    always_comb begin
        raw      = trama[14:3];
        producto = 15'({raw, 2'b00}) + 15'(raw);
        decimas  = producto[14:1];
        if (int'(decimas) > TEMP_MAX) temp_sat = ANCHO_TEMP'(TEMP_MAX);
        else                          temp_sat = ANCHO_TEMP'(decimas);
    end

    assign trama_unused = ^{trama[15], trama[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_entrada <= '0;
            dato_valido  <= 1'b0;
            falla        <= 1'b0;
        end else begin
            dato_valido <= (estado == FIN);
            if (estado == FIN) begin
                falla <= trama[2];
                if (!trama[2]) temp_entrada <= temp_sat;
            end
        end
    end

endmodule

// File: tb/tb_lector_sensor_temp.sv
// Directed bench for lector_sensor_temp: sensor model on the SPI wires and a
// scoreboard queue of expected samples popped on each dato_valido.
module tb_lector_sensor_temp;

    localparam int DIV   = 4;
    localparam int PAUSA = 10;
    localparam int AT    = 10;

    logic          clk = 1'b0;
    logic          rst, inicio, auto_en, miso;
    logic          cs_n, sclk, dato_valido, falla, ocupado;
    logic [AT-1:0] temp_entrada;

    typedef struct {
        logic [AT-1:0] temp;
        logic          falla;
    } esperado_t;

    esperado_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          dv_seen = 0;
    logic [15:0] frame_tx = 16'h0000;
    int          bit_i = 15;

    lector_sensor_temp #(.DIV_SCLK(DIV), .PAUSA_CICLOS(PAUSA), .ANCHO_TEMP(AT)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .auto_en(auto_en), .miso(miso),
        .cs_n(cs_n), .sclk(sclk), .temp_entrada(temp_entrada),
        .dato_valido(dato_valido), .falla(falla), .ocupado(ocupado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor: first bit on cs_n fall, next bit on each sclk falling edge.
    always @(negedge cs_n) begin
        bit_i = 15;
        miso  = frame_tx[15];
    end
    always @(negedge sclk) begin
        if (!cs_n && bit_i > 0) begin
            bit_i = bit_i - 1;
            miso  = frame_tx[bit_i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dato_valido) begin
            esperado_t e;
            dv_seen++;
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_temp", 32'(temp_entrada), 32'(e.temp));
                check("sb_falla", 32'(falla), 32'(e.falla));
            end
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cs(input logic val, input int budget, input string tag);
        int i = 0;
        while (cs_n !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(cs_n === val), 32'd1);
    endtask

    // Starts a frame with inicio and measures its timing from cycle 1 onwards.
    task automatic run_frame(input logic [15:0] f, input logic [AT-1:0] et, input logic ef,
                             input bit pulsos);
        int dv_k = 0, cs_low = 0, rises = 0, extra_low = 0;
        logic prev = 1'b0;
        frame_tx = f;
        sb.push_back('{temp: et, falla: ef});
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        check("ocupado_c1", 32'(ocupado), 32'd1);
        for (int k = 1; k <= 300 && dv_k == 0; k++) begin
            if (dato_valido) dv_k = k;
            if (!cs_n) cs_low++;
            if (sclk && !prev) rises++;
            prev = sclk;
            if (dv_k == 0) begin
                inicio = pulsos && (k == 50);
                @(negedge clk);
            end
        end
        check("dv_cycle", 32'(dv_k), 32'd134);
        check("cs_low", 32'(cs_low), 32'd132);
        check("sclk_rises", 32'(rises), 32'd16);
        check("ocupado_dv", 32'(ocupado), 32'd1);
        inicio = pulsos;
        @(negedge clk);
        inicio = 1'b0;
        check("ocupado_after", 32'(ocupado), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        if (pulsos) begin
            repeat (150) begin
                if (!cs_n) extra_low++;
                @(negedge clk);
            end
            check("no_extra_frame", 32'(extra_low), 32'd0);
        end
    endtask

    initial begin
        int t1, t2, idle_low, dv_before;
        rst = 1'b1; inicio = 1'b0; auto_en = 1'b0; miso = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_temp", 32'(temp_entrada), 32'd0);
        check("rst_dv", 32'(dato_valido), 32'd0);
        check("rst_falla", 32'(falla), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(16'h0500, AT'(400), 1'b0, 1'b0);
        run_frame(16'h0248, AT'(182), 1'b0, 1'b1);
        run_frame(16'h7FF8, AT'(1023), 1'b0, 1'b0);
        run_frame(16'h0500, AT'(400), 1'b0, 1'b0);
        run_frame(16'h0504, AT'(400), 1'b1, 1'b0);
        run_frame(16'h0500, AT'(400), 1'b0, 1'b0);

        // Automatic mode: two frames, inicio pulsed mid-frame, auto_en dropped in PAUSA.
        frame_tx = 16'h0500;
        sb.push_back('{temp: AT'(400), falla: 1'b0});
        sb.push_back('{temp: AT'(400), falla: 1'b0});
        auto_en = 1'b1;
        @(negedge clk);
        wait_cs(1'b0, 10, "auto_fall1");
        t1 = cyc;
        repeat (40) @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        wait_cs(1'b1, 200, "auto_rise1");
        wait_cs(1'b0, 200, "auto_fall2");
        t2 = cyc;
        check("auto_period", 32'(t2 - t1), 32'd144);
        dv_before = dv_seen;
        for (int i = 0; i < 200 && dv_seen == dv_before; i++) @(negedge clk);
        check("auto_dv2", 32'(dv_seen - dv_before), 32'd1);
        auto_en = 1'b0;
        @(negedge clk);
        check("auto_drop_idle", 32'(ocupado), 32'd0);
        idle_low = 0;
        repeat (200) begin
            if (!cs_n) idle_low++;
            @(negedge clk);
        end
        check("auto_stopped", 32'(idle_low), 32'd0);
        check("auto_sb_drained", 32'(sb.size()), 32'd0);

        // Reset after bit 7 has been sampled: cycle 69 of the frame.
        frame_tx = 16'h0500;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (68) @(negedge clk);
        dv_before = dv_seen;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check("mid_rst_sclk", 32'(sclk), 32'd0);
        check("mid_rst_temp", 32'(temp_entrada), 32'd0);
        check("mid_rst_ocupado", 32'(ocupado), 32'd0);
        check("mid_rst_falla", 32'(falla), 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_rst_no_dv", 32'(dv_seen - dv_before), 32'd0);
        check("mid_rst_cs_idle", 32'(cs_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
